nano_decoder_sequencer: RTL and testbench
=========================================

# nano_decoder_sequencer

- Program sequencer and instruction decoder for the 4-bit nano processor.
- Fetches 8-bit instructions from program memory with a valid handshake and holds the current instruction in an instruction register (`ir`).
- Executes jumps and conditional jumps. The conditional jump tests the `r_eq_0` flag.
- Drives every control input of the computational unit: register enables, data-bus source select, index-update select, ALU operand selects and ALU nibble.

## Interface
Parameters: none.

Ports:
- `clk` — input, 1 — system clock. All state changes on the rising edge.
- `reset_n` — input, 1 — reset, asynchronous, active-low.
- `pm_data_in` — input, 8 — instruction word from program memory.
- `pm_valid` — input, 1 — `pm_data_in` is valid this cycle.
- `r_eq_0` — input, 1 — registered ALU-result-zero flag from the computational unit.
- `pm_rd` — output, 1 — instruction fetch request.
- `pm_address` — output, 8 — program counter.
- `reg_en` — output, 9 — register write enables. Bit map: 0 x0, 1 x1, 2 y0, 3 y1, 4 r, 5 m, 6 i, 7 dm, 8 o_reg.
- `source_sel` — output, 4 — data-bus source. Codes: 0-7 = x0, x1, y0, y1, r, m, i, dm; 8 = pm_data; 9 = i_pins.
- `i_sel` — output, 1 — index mux select: 0 = data bus, 1 = i + m.
- `x_sel` — output, 1 — ALU x-operand select; equals `ir[4]`.
- `y_sel` — output, 1 — ALU y-operand select; equals `ir[3]`.
- `ir_nibble` — output, 4 — equals `ir[3:0]`.

## Operation
FSM states:
- **FETCH** (reset state)
  - `pm_rd`=1 and `pm_address`=pc, both held until `pm_valid`=1.
  - On a cycle with `pm_valid`: `ir` ← `pm_data_in`, pc ← pc+1 (8-bit, 0xFF wraps to 0x00), go to EXEC.
- **EXEC**
  - Exactly one cycle. `pm_rd`=0. Decoded `reg_en` active.
  - Next state is always FETCH.
- `reg_en` = 0 in every state except EXEC.
- `x_sel`, `y_sel`, `ir_nibble` follow `ir` in all states.

Decode of `ir[7:0]`:
- `0ddd_nnnn` **load**
  - `source_sel`=8; `reg_en` bit for dst ddd.
- `10dd_dsss` **move**
  - `source_sel`=sss. If sss==ddd, `source_sel`=9 (i_pins).
  - `reg_en` bit for dst ddd.
- `110x_yfff` **ALU**
  - `reg_en[4]`=1 only.
  - `source_sel`=0 (don't-care for this instruction).
- `1110_aaaa` **jmp**
  - pc ← {pc[7:4], aaaa}, using the already-incremented pc.
  - `reg_en`=0.
- `1111_aaaa` **jnz**
  - If `r_eq_0`==0: pc ← {pc[7:4], aaaa}.
  - Otherwise pc keeps its incremented value.
  - `reg_en`=0.

Destination code ddd → `reg_en` bit:
- 0→0, 1→1, 2→2, 3→3
- 4→8 (o_reg)
- 5→5, 6→6
- 7→7 (dm write)

Index post-increment (load and move only):
- Applies when ddd==7, or (move and sss==7).
- Sets `reg_en[6]`=1 and `i_sel`=1.
- Exception: if ddd==6, the destination write wins. `i_sel`=0 and the data bus loads i.
- In all other cases `i_sel`=0.

## Timing
Reset (asynchronous, `reset_n`=0):
- pc=0x00, `ir`=0x00, state=FETCH.
- `reg_en`=0, `source_sel`=0, `i_sel`=0, `x_sel`=0, `y_sel`=0, `ir_nibble`=0.
- `pm_rd`=1 combinationally once state is FETCH. It is held at 0 while `reset_n`=0.

Instruction timing:
- Minimum 2 cycles per instruction: one FETCH cycle when `pm_valid` is high on the first fetch cycle, then one EXEC cycle.
- Each extra cycle with `pm_valid` low adds one FETCH cycle.
- `pm_address` is stable throughout FETCH. `pm_valid` outside FETCH is ignored.
- Controls are combinational from `ir` and state; they are valid for the whole EXEC cycle.
- The computational unit registers update on the rising edge that ends EXEC.
- `jnz` samples `r_eq_0` during EXEC. An ALU instruction immediately preceding it has already updated `r_eq_0`.

Boundaries:
- Jump target page comes from the incremented pc. A jmp at 0x0F jumps within page 0x1_.
- Reset asserted mid-EXEC aborts the instruction. `reg_en` goes to 0 immediately.
- `pm_valid` and reset in the same cycle: reset wins.

## Configuration
- `NANO_COND_JUMP_EN` defined: `1111_aaaa` decodes as jnz as described above.
- Undefined:
  - `1111_aaaa` is a NOP. pc increments only, `reg_en`=0.
  - The `r_eq_0` input is ignored.

## Test plan
- Reset, `pm_valid` tied 1, program `0x05` at address 0 (load x0, 5):
  - `pm_address`=0x00 in cycle 1, then EXEC with `reg_en`=0x001, `source_sel`=8, `ir_nibble`=5.
  - `pm_address`=0x01 next.
- Move `0x89` (ddd=1, sss=1):
  - `source_sel`=9, `reg_en`=0x002.
- Move `0xB9` (dst dm, src x1):
  - `reg_en`=0x0C0, `i_sel`=1, `source_sel`=1.
- Move `0xB7` (dst i, src dm):
  - `reg_en`=0x040, `i_sel`=0, `source_sel`=7.
- ALU `0xD2` (x1, y0, add):
  - `reg_en`=0x010, `x_sel`=1, `y_sel`=0, `ir_nibble`=2.
- jmp `0xE3` fetched at 0x0F → next `pm_address`=0x13.
- jnz `0xF4` at 0x20:
  - With `r_eq_0`=0 → next 0x24.
  - With `r_eq_0`=1 → next 0x21.
  - Macro undefined → 0x21 regardless of `r_eq_0`.
- Fetch stall: hold `pm_valid`=0 for 3 cycles → `pm_rd`=1, `pm_address` constant, `reg_en`=0 throughout.
- Reset pulse during EXEC of `0x05` → `reg_en`=0 asynchronously; fetch restarts at 0x00.

Source files
------------

// File: rtl/nano_decoder_sequencer.sv
// Program sequencer / instruction decoder for the 4-bit nano processor.
// Optional macro NANO_COND_JUMP_EN: 1111_aaaa decodes as jnz on r_eq_0 (else NOP).
module nano_decoder_sequencer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] pm_data_in,
  input  logic       pm_valid,
  input  logic       r_eq_0,
  output logic       pm_rd,
  output logic [7:0] pm_address,
  output logic [8:0] reg_en,
  output logic [3:0] source_sel,
  output logic       i_sel,
  output logic       x_sel,
  output logic       y_sel,
  output logic [3:0] ir_nibble
);

  typedef enum logic {FETCH = 1'b0, EXEC = 1'b1} state_t;

  state_t     state;
  logic [7:0] pc;
  logic [7:0] ir;

  // ddd 4 maps to the output register, everything else to its own bit
  function automatic logic [8:0] dst_bit(input logic [2:0] d);
    dst_bit = (d == 3'd4) ? 9'h100 : (9'd1 << d);
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= FETCH;
      pc    <= 8'h00;
      ir    <= 8'h00;
    end else begin
      case (state)
        FETCH: if (pm_valid) begin
          ir    <= pm_data_in;
          pc    <= pc + 8'd1;
          state <= EXEC;
        end
        EXEC: begin
          state <= FETCH;
          // pc already holds the incremented value, so the page comes from it
          if (ir[7:4] == 4'hE)
            pc <= {pc[7:4], ir[3:0]};
`ifdef NANO_COND_JUMP_EN
          else if (ir[7:4] == 4'hF && !r_eq_0)
            pc <= {pc[7:4], ir[3:0]};
`endif
        end
        default: state <= FETCH;
      endcase
    end
  end

`ifndef NANO_COND_JUMP_EN
  logic unused_r_eq_0;
  assign unused_r_eq_0 = r_eq_0;
`endif

  assign pm_rd      = reset_n && (state == FETCH);
  assign pm_address = pc;
  assign x_sel      = ir[4];
  assign y_sel      = ir[3];
  assign ir_nibble  = ir[3:0];

  logic [2:0] ddd;
  logic [2:0] sss;
  logic       post_inc;

  always_comb begin
    reg_en     = 9'h000;
    source_sel = 4'd0;
    i_sel      = 1'b0;
    ddd        = ir[7] ? ir[5:3] : ir[6:4];
    sss        = ir[2:0];
    post_inc   = 1'b0;
    if (state == EXEC) begin
      if (!ir[7]) begin
        reg_en     = dst_bit(ddd);
        source_sel = 4'd8;
        post_inc   = (ddd == 3'd7);
      end else if (ir[7:6] == 2'b10) begin
        reg_en     = dst_bit(ddd);
        source_sel = (sss == ddd) ? 4'd9 : {1'b0, sss};
        post_inc   = (ddd == 3'd7) || (sss == 3'd7);
      end else if (ir[7:5] == 3'b110) begin
        reg_en = 9'h010;
      end
      // when i itself is the destination the bus write wins over i + m
      if (post_inc) begin
        reg_en = reg_en | 9'h040;
        i_sel  = (ddd != 3'd6);
      end
    end
  end

endmodule

// File: tb/tb_nano_decoder_sequencer.sv
// Self-checking bench for nano_decoder_sequencer: directed program steps plus
// randomized instruction stream against an instruction-level reference model.
module tb_nano_decoder_sequencer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pm_data_in = 8'h00;
  logic       pm_valid = 1'b0;
  logic       r_eq_0 = 1'b0;
  logic       pm_rd;
  logic [7:0] pm_address;
  logic [8:0] reg_en;
  logic [3:0] source_sel;
  logic       i_sel, x_sel, y_sel;
  logic [3:0] ir_nibble;

  nano_decoder_sequencer dut (
    .clk(clk), .reset_n(reset_n), .pm_data_in(pm_data_in), .pm_valid(pm_valid),
    .r_eq_0(r_eq_0), .pm_rd(pm_rd), .pm_address(pm_address), .reg_en(reg_en),
    .source_sel(source_sel), .i_sel(i_sel), .x_sel(x_sel), .y_sel(y_sel),
    .ir_nibble(ir_nibble)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: instruction-level view of the processor front end
  logic       m_exec = 1'b0;
  logic [7:0] m_pc = 8'h00;
  logic [7:0] m_ir = 8'h00;

  // snapshot of the last EXEC cycle's outputs
  logic [8:0] s_reg_en;
  logic [3:0] s_src, s_nib;
  logic       s_isel, s_xsel, s_ysel;

`ifdef NANO_COND_JUMP_EN
  localparam bit COND_EN = 1'b1;
`else
  localparam bit COND_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [8:0] reg_of(input int d);
    return (d == 4) ? 9'h100 : 9'h001 << d;
  endfunction

  // expected EXEC controls derived from the instruction-set rules
  task automatic expect_ctrl(input logic [7:0] ins, output logic [8:0] re,
                             output logic [3:0] ss, output logic is);
    int d, s;
    bit inc;
    re = '0; ss = '0; is = 1'b0; inc = 0;
    d = 0; s = 0;
    if (ins < 8'h80) begin
      d = int'(ins) / 16;
      re = reg_of(d); ss = 4'd8; inc = (d == 7);
    end else if (ins < 8'hC0) begin
      d = (int'(ins) / 8) % 8; s = int'(ins) % 8;
      re = reg_of(d); ss = (d == s) ? 4'd9 : 4'(s);
      inc = (d == 7) || (s == 7);
    end else if (ins < 8'hE0) begin
      re = 9'h010;
    end
    if (inc) begin
      re = re | 9'h040;
      is = (d != 6);
    end
  endtask

  task automatic check_now();
    logic [8:0] re; logic [3:0] ss; logic is;
    expect_ctrl(m_ir, re, ss, is);
    chk("pm_rd", pm_rd, !m_exec);
    chk("pm_address", pm_address, m_pc);
    chk("reg_en", reg_en, m_exec ? re : 9'h000);
    chk("source_sel", source_sel, m_exec ? ss : 4'd0);
    chk("i_sel", i_sel, m_exec ? is : 1'b0);
    chk("x_sel", x_sel, m_ir[4]);
    chk("y_sel", y_sel, m_ir[3]);
    chk("ir_nibble", ir_nibble, m_ir[3:0]);
  endtask

  // one clock: drive inputs at negedge, check, then advance model for the posedge
  task automatic step(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    pm_valid = v; pm_data_in = d; r_eq_0 = r;
    #1;
    check_now();
    if (m_exec) begin
      s_reg_en = reg_en; s_src = source_sel; s_isel = i_sel;
      s_xsel = x_sel; s_ysel = y_sel; s_nib = ir_nibble;
      if (m_ir[7:4] == 4'hE || (COND_EN && m_ir[7:4] == 4'hF && !r))
        m_pc = {m_pc[7:4], m_ir[3:0]};
      m_exec = 1'b0;
    end else if (v) begin
      m_ir = d; m_pc = m_pc + 8'd1; m_exec = 1'b1;
    end
  endtask

  task automatic instr(input logic [7:0] d, input logic r);
    step(1'b1, d, r);
    step(1'($urandom_range(1)), 8'($urandom), r);
  endtask

  task automatic addr_after(input string tag, input logic [7:0] exp);
    @(posedge clk); #1;
    chk(tag, pm_address, exp);
  endtask

  initial begin
    #1;
    chk("rst_pm_rd", pm_rd, 1'b0);
    chk("rst_reg_en", reg_en, 9'h000);
    chk("rst_source_sel", source_sel, 4'd0);
    chk("rst_addr", pm_address, 8'h00);
    chk("rst_nibble", ir_nibble, 4'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // load x0, 5 at address 0
    instr(8'h05, 1'b0);
    chk("tp_load_reg_en", s_reg_en, 9'h001);
    chk("tp_load_src", s_src, 4'd8);
    chk("tp_load_nib", s_nib, 4'd5);
    addr_after("tp_load_next_addr", 8'h01);

    // fetch stall at 0x01
    repeat (3) begin
      step(1'b0, 8'hFF, 1'b0);
      chk("tp_stall_rd", pm_rd, 1'b1);
      chk("tp_stall_addr", pm_address, 8'h01);
      chk("tp_stall_reg_en", reg_en, 9'h000);
    end

    instr(8'hEF, 1'b0);             // jmp -> 0x0F
    addr_after("tp_jmp_0f", 8'h0F);
    instr(8'hE3, 1'b0);             // jmp at 0x0F lands in page 1
    addr_after("tp_jmp_page", 8'h13);

    instr(8'h89, 1'b0);
    chk("tp_mv89_src", s_src, 4'd9);
    chk("tp_mv89_reg_en", s_reg_en, 9'h002);
    instr(8'hB9, 1'b0);
    chk("tp_mvB9_reg_en", s_reg_en, 9'h0C0);
    chk("tp_mvB9_isel", s_isel, 1'b1);
    chk("tp_mvB9_src", s_src, 4'd1);
    instr(8'hB7, 1'b0);
    chk("tp_mvB7_reg_en", s_reg_en, 9'h040);
    chk("tp_mvB7_isel", s_isel, 1'b0);
    chk("tp_mvB7_src", s_src, 4'd7);
    instr(8'hD2, 1'b0);
    chk("tp_alu_reg_en", s_reg_en, 9'h010);
    chk("tp_alu_x", s_xsel, 1'b1);
    chk("tp_alu_y", s_ysel, 1'b0);
    chk("tp_alu_nib", s_nib, 4'd2);

    // pc is 0x17; walk to 0x20 with random loads
    repeat (9) instr(8'($urandom_range(127)), 1'($urandom_range(1)));
    addr_after("tp_at_20", 8'h20);
    instr(8'hF4, 1'b0);
    chk("tp_jnz_reg_en", s_reg_en, 9'h000);
    addr_after("tp_jnz_r0", COND_EN ? 8'h24 : 8'h21);
    instr(8'hE0, 1'b0);             // back to 0x20
    instr(8'hF4, 1'b1);
    addr_after("tp_jnz_r1", 8'h21);

    // asynchronous reset during EXEC of load x0, 5
    step(1'b1, 8'h05, 1'b0);
    @(negedge clk); #1;
    chk("tp_rst_exec_active", reg_en, 9'h001);
    reset_n = 1'b0; #1;
    chk("tp_rst_exec_reg_en", reg_en, 9'h000);
    chk("tp_rst_exec_rd", pm_rd, 1'b0);
    m_exec = 1'b0; m_pc = 8'h00; m_ir = 8'h00;
    @(posedge clk); #2;
    reset_n = 1'b1;                 // released mid-cycle, before the next negedge
    chk("tp_rst_restart_addr", pm_address, 8'h00);

    // randomized stream with random stalls
    repeat (400) begin
      repeat ($urandom_range(2)) step(1'b0, 8'($urandom), 1'($urandom_range(1)));
      instr(8'($urandom), 1'($urandom_range(1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
